// File: rtl/vga_timing_generator.sv
// Raster timing for the pong screen: free-running pixel/line counters plus
// sync and blanking delayed to line up with the colour returned by the pixel source.
module vga_timing_generator #(
    parameter int H_VISIBLE     = 800,
    parameter int H_FRONT       = 56,
    parameter int H_SYNC        = 120,
    parameter int H_BACK        = 64,
    parameter int V_VISIBLE     = 600,
    parameter int V_FRONT       = 37,
    parameter int V_SYNC        = 6,
    parameter int V_BACK        = 23,
    parameter int SYNC_POLARITY = 1,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic        VGA_CLOCK,
    input  logic        RESET_N,
    input  logic [2:0]  PIXEL,
    output logic [10:0] PIXEL_H,
    output logic [10:0] PIXEL_V,
    output logic        VISIBLE,
    output logic        FRAME_START,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL >= 2048 || V_TOTAL >= 2048) begin : g_total_check
        $error("vga_timing_generator: H_TOTAL and V_TOTAL must be below 2048");
    end
    if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 7) begin : g_latency_check
        $error("vga_timing_generator: PIXEL_LATENCY must be in 0..7");
    end

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic        SYNC_INV = (SYNC_POLARITY == 0);

    logic       h_active;
    logic       v_active;
    logic       hs_raw;
    logic       vs_raw;
    logic [2:0] raw_bus;
    logic [2:0] dly_bus;
    logic       hs_q;
    logic       vs_q;
    logic [2:0] rgb_q;

    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            PIXEL_H <= '0;
            PIXEL_V <= '0;
        end else if (PIXEL_H == H_LAST) begin
            PIXEL_H <= '0;
            PIXEL_V <= (PIXEL_V == V_LAST) ? 11'd0 : PIXEL_V + 11'd1;
        end else begin
            PIXEL_H <= PIXEL_H + 11'd1;
        end
    end

    assign h_active    = (PIXEL_H < H_VIS);
    assign v_active    = (PIXEL_V < V_VIS);
    assign VISIBLE     = h_active & v_active;
    assign hs_raw      = (PIXEL_H >= HS_START) && (PIXEL_H < HS_END);
    assign vs_raw      = (PIXEL_V >= VS_START) && (PIXEL_V < VS_END);
    assign FRAME_START = (PIXEL_H == 11'd0) && (PIXEL_V == 11'd0);

    // Bus order {hs, vs, visible}; all-zero is the inactive state of every stage.
    assign raw_bus = {hs_raw, vs_raw, VISIBLE};

    if (PIXEL_LATENCY == 0) begin : g_no_delay
        assign dly_bus = raw_bus;
    end else begin : g_delay
        logic [2:0] stage [PIXEL_LATENCY];

        always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
            if (!RESET_N) begin
                for (int i = 0; i < PIXEL_LATENCY; i++) begin
                    stage[i] <= '0;
                end
            end else begin
                stage[0] <= raw_bus;
                for (int i = 1; i < PIXEL_LATENCY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dly_bus = stage[PIXEL_LATENCY-1];
    end

    // Colour and its delayed blanking are registered in the same edge.
    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= dly_bus[2];
            vs_q  <= dly_bus[1];
            rgb_q <= PIXEL & {3{dly_bus[0]}};
        end
    end

    assign VGA_HS = hs_q ^ SYNC_INV;
    assign VGA_VS = vs_q ^ SYNC_INV;
    assign VGA_R  = rgb_q[2];
    assign VGA_G  = rgb_q[1];
    assign VGA_B  = rgb_q[0];

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator on a shrunken 15x8 raster (120 clocks per frame),
// three instances covering latency 1/active-high, latency 0 and 3/active-low sync.
module tb_vga_timing_generator;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int FRAME = 120;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] pix_a = 3'd7;
    logic [2:0] pix_b = 3'd5;
    logic [2:0] pix_c = 3'd3;

    logic [10:0] a_h, a_v, b_h, b_v, c_h, c_v;
    logic a_vis, a_fs, a_hs, a_vs, a_r, a_g, a_b;
    logic b_vis, b_fs, b_hs, b_vs, b_r, b_g, b_b;
    logic c_vis, c_fs, c_hs, c_vs, c_r, c_g, c_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    vga_timing_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POLARITY(1), .PIXEL_LATENCY(1)
    ) u_dut_a (
        .VGA_CLOCK(clk), .RESET_N(rst_n), .PIXEL(pix_a),
        .PIXEL_H(a_h), .PIXEL_V(a_v), .VISIBLE(a_vis), .FRAME_START(a_fs),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b)
    );

    vga_timing_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POLARITY(0), .PIXEL_LATENCY(0)
    ) u_dut_b (
        .VGA_CLOCK(clk), .RESET_N(rst_n), .PIXEL(pix_b),
        .PIXEL_H(b_h), .PIXEL_V(b_v), .VISIBLE(b_vis), .FRAME_START(b_fs),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b)
    );

    vga_timing_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POLARITY(0), .PIXEL_LATENCY(3)
    ) u_dut_c (
        .VGA_CLOCK(clk), .RESET_N(rst_n), .PIXEL(pix_c),
        .PIXEL_H(c_h), .PIXEL_V(c_v), .VISIBLE(c_vis), .FRAME_START(c_fs),
        .VGA_HS(c_hs), .VGA_VS(c_vs), .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    // n = rising edges since reset release; sync fields are {HS, VS}.
    typedef struct {
        int         n;
        int         h;
        int         v;
        logic       vis;
        logic       fs;
        logic [1:0] a_sync;
        logic [2:0] a_rgb;
        logic [1:0] b_sync;
        logic [2:0] b_rgb;
        logic [1:0] c_sync;
        logic [2:0] c_rgb;
    } vec_t;

    vec_t vecs [20];

    initial begin
        int cnt;
        int fs_cnt, hs_cnt, vs_cnt, lit_a, lit_b, bhs_low, cvs_low;
        int max_h, max_v;
        int lit5, bad5;

        vecs[0]  = '{0,   0,  0, 1'b1, 1'b1, 2'b00, 3'd0, 2'b11, 3'd0, 2'b11, 3'd0};
        vecs[1]  = '{1,   1,  0, 1'b1, 1'b0, 2'b00, 3'd0, 2'b11, 3'd5, 2'b11, 3'd0};
        vecs[2]  = '{2,   2,  0, 1'b1, 1'b0, 2'b00, 3'd7, 2'b11, 3'd5, 2'b11, 3'd0};
        vecs[3]  = '{4,   4,  0, 1'b1, 1'b0, 2'b00, 3'd7, 2'b11, 3'd5, 2'b11, 3'd3};
        vecs[4]  = '{10,  10, 0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b11, 3'd0, 2'b11, 3'd3};
        vecs[5]  = '{11,  11, 0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b01, 3'd0, 2'b11, 3'd3};
        vecs[6]  = '{12,  12, 0, 1'b0, 1'b0, 2'b10, 3'd0, 2'b01, 3'd0, 2'b11, 3'd0};
        vecs[7]  = '{14,  14, 0, 1'b0, 1'b0, 2'b10, 3'd0, 2'b11, 3'd0, 2'b01, 3'd0};
        vecs[8]  = '{15,  0,  1, 1'b1, 1'b0, 2'b00, 3'd0, 2'b11, 3'd0, 2'b01, 3'd0};
        vecs[9]  = '{17,  2,  1, 1'b1, 1'b0, 2'b00, 3'd7, 2'b11, 3'd5, 2'b11, 3'd0};
        vecs[10] = '{60,  0,  4, 1'b0, 1'b0, 2'b00, 3'd0, 2'b11, 3'd0, 2'b01, 3'd0};
        vecs[11] = '{62,  2,  4, 1'b0, 1'b0, 2'b00, 3'd0, 2'b11, 3'd0, 2'b11, 3'd0};
        vecs[12] = '{77,  2,  5, 1'b0, 1'b0, 2'b01, 3'd0, 2'b10, 3'd0, 2'b11, 3'd0};
        vecs[13] = '{79,  4,  5, 1'b0, 1'b0, 2'b01, 3'd0, 2'b10, 3'd0, 2'b10, 3'd0};
        vecs[14] = '{104, 14, 6, 1'b0, 1'b0, 2'b11, 3'd0, 2'b10, 3'd0, 2'b00, 3'd0};
        vecs[15] = '{107, 2,  7, 1'b0, 1'b0, 2'b00, 3'd0, 2'b11, 3'd0, 2'b10, 3'd0};
        vecs[16] = '{119, 14, 7, 1'b0, 1'b0, 2'b10, 3'd0, 2'b11, 3'd0, 2'b01, 3'd0};
        vecs[17] = '{120, 0,  0, 1'b1, 1'b1, 2'b00, 3'd0, 2'b11, 3'd0, 2'b01, 3'd0};
        vecs[18] = '{122, 2,  0, 1'b1, 1'b0, 2'b00, 3'd7, 2'b11, 3'd5, 2'b11, 3'd0};
        vecs[19] = '{124, 4,  0, 1'b1, 1'b0, 2'b00, 3'd7, 2'b11, 3'd5, 2'b11, 3'd3};

        // ---- reset held with clock running ----
        repeat (4) @(negedge clk);
        check("rst a_h", a_h, 0);
        check("rst a_v", a_v, 0);
        check("rst a_vis", a_vis, 1);
        check("rst a_fs", a_fs, 1);
        check("rst a_sync", {a_hs, a_vs}, 2'b00);
        check("rst a_rgb", {a_r, a_g, a_b}, 3'd0);
        check("rst b_sync", {b_hs, b_vs}, 2'b11);
        check("rst c_sync", {c_hs, c_vs}, 2'b11);

        // ---- release and table walk ----
        rst_n = 1'b1;
        cyc = 0;
        foreach (vecs[i]) begin
            while (cyc < vecs[i].n) step();
            check($sformatf("v%0d a_h", i), a_h, vecs[i].h);
            check($sformatf("v%0d a_v", i), a_v, vecs[i].v);
            check($sformatf("v%0d b_h", i), b_h, vecs[i].h);
            check($sformatf("v%0d b_v", i), b_v, vecs[i].v);
            check($sformatf("v%0d c_h", i), c_h, vecs[i].h);
            check($sformatf("v%0d c_v", i), c_v, vecs[i].v);
            check($sformatf("v%0d vis", i), {a_vis, b_vis, c_vis}, {3{vecs[i].vis}});
            check($sformatf("v%0d fs", i), {a_fs, b_fs, c_fs}, {3{vecs[i].fs}});
            check($sformatf("v%0d a_sync", i), {a_hs, a_vs}, vecs[i].a_sync);
            check($sformatf("v%0d a_rgb", i), {a_r, a_g, a_b}, vecs[i].a_rgb);
            check($sformatf("v%0d b_sync", i), {b_hs, b_vs}, vecs[i].b_sync);
            check($sformatf("v%0d b_rgb", i), {b_r, b_g, b_b}, vecs[i].b_rgb);
            check($sformatf("v%0d c_sync", i), {c_hs, c_vs}, vecs[i].c_sync);
            check($sformatf("v%0d c_rgb", i), {c_r, c_g, c_b}, vecs[i].c_rgb);
        end

        // ---- one full frame of statistics ----
        fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; lit_a = 0; lit_b = 0;
        bhs_low = 0; cvs_low = 0; max_h = 0; max_v = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (a_fs) fs_cnt++;
            if (a_hs) hs_cnt++;
            if (a_vs) vs_cnt++;
            if ({a_r, a_g, a_b} == 3'd7) lit_a++;
            if ({b_r, b_g, b_b} == 3'd5) lit_b++;
            if (!b_hs) bhs_low++;
            if (!c_vs) cvs_low++;
            if (int'(a_h) > max_h) max_h = int'(a_h);
            if (int'(a_v) > max_v) max_v = int'(a_v);
            step();
        end
        check("frame fs pulses", fs_cnt, 1);
        check("frame a_hs clocks", hs_cnt, HS * 8);
        check("frame a_vs clocks", vs_cnt, VS * 15);
        check("frame a lit clocks", lit_a, HV * VV);
        check("frame b lit clocks", lit_b, HV * VV);
        check("frame b_hs low clocks", bhs_low, HS * 8);
        check("frame c_vs low clocks", cvs_low, VS * 15);
        check("max h", max_h, 14);
        check("max v", max_v, 7);

        // ---- frame period between FRAME_START pulses ----
        cnt = 0;
        while (a_fs !== 1'b1 && cnt < 300) begin step(); cnt++; end
        check("fs seen", a_fs, 1'b1);
        step();
        cnt = 1;
        while (a_fs !== 1'b1 && cnt < 300) begin step(); cnt++; end
        check("frame period", cnt, FRAME);

        // ---- single lit pixel: PIXEL is a register of (h == 5) ----
        lit5 = 0; bad5 = 0;
        for (int i = 0; i < FRAME + 2; i++) begin
            int k;
            logic exp_lit;
            pix_a = (((cyc - 1) % 15) == 5) ? 3'd7 : 3'd0;
            k = cyc - 2;
            exp_lit = ((k % 15) == 5) && (((k / 15) % 8) < VV);
            if (i >= 2) begin
                if ({a_r, a_g, a_b} == 3'd7) lit5++;
                if (({a_r, a_g, a_b} == 3'd7) != exp_lit) bad5++;
            end
            step();
        end
        check("pixel5 lit clocks", lit5, VV);
        check("pixel5 misplaced clocks", bad5, 0);
        pix_a = 3'd7;

        // ---- async reset mid-frame during both sync pulses of dut a ----
        cnt = 0;
        while ((cyc % FRAME) != 103 && cnt < 300) begin step(); cnt++; end
        check("pre-reset a_sync", {a_hs, a_vs}, 2'b11);
        check("pre-reset c_sync", {c_hs, c_vs}, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        check("async a_h", a_h, 0);
        check("async a_v", a_v, 0);
        check("async fs", a_fs, 1);
        check("async a_sync", {a_hs, a_vs}, 2'b00);
        check("async a_rgb", {a_r, a_g, a_b}, 3'd0);
        check("async b_sync", {b_hs, b_vs}, 2'b11);
        check("async c_sync", {c_hs, c_vs}, 2'b11);
        repeat (3) @(negedge clk);
        check("held a_h", a_h, 0);
        rst_n = 1'b1;
        cyc = 0;
        step();
        check("restart a_h", a_h, 1);
        cnt = 1;
        while (a_fs !== 1'b1 && cnt < 300) begin step(); cnt++; end
        check("restart frame period", cnt, FRAME);

        // ---- report ----
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
